// File: rtl/led_breathe_pwm.sv
// rtl/led_breathe_pwm.sv - breathing LED: duty ramps 0->max->0 on 1 ms ticks, with holds at both ends
module led_breathe_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_MS  = 4,
  parameter int HOLD_MS  = 200
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iTICK_1MS,
  input  logic                iEN,
  output logic                oLED,
  output logic [PWM_BITS-1:0] oDUTY,
  output logic [2:0]          oSTATE,
  output logic                oCYCLE
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } breathState;

  localparam int MS_MAX = (HOLD_MS > STEP_MS) ? HOLD_MS : STEP_MS;
  localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [MS_W-1:0]     STEP_LAST = MS_W'(STEP_MS - 1);
  localparam logic [MS_W-1:0]     HOLD_LAST = MS_W'(HOLD_MS - 1);

  breathState          state, stateNext;
  logic [PWM_BITS-1:0] dutyNext;
  logic [MS_W-1:0]     msCnt, msCntNext;
  logic                cycleNext;
  logic                tickQ;
  logic                tick;
  logic [PWM_BITS-1:0] pwmCnt;
  logic [PWM_BITS-1:0] dutyActive;

  assign tick   = iTICK_1MS & ~tickQ;
  assign oSTATE = state;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      oDUTY  <= '0;
      msCnt  <= '0;
      oCYCLE <= 1'b0;
    end else begin
      state  <= stateNext;
      oDUTY  <= dutyNext;
      msCnt  <= msCntNext;
      oCYCLE <= cycleNext;
    end
  end

  always_comb begin
    stateNext = state;
    dutyNext  = oDUTY;
    msCntNext = msCnt;
    cycleNext = 1'b0;
    if (!iEN) begin
      stateNext = IDLE;
      dutyNext  = '0;
      msCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          // The tick seen while leaving IDLE is deliberately dropped.
          stateNext = UP;
          dutyNext  = '0;
          msCntNext = '0;
        end
        UP: begin
          if (tick) begin
            if (msCnt == STEP_LAST) begin
              msCntNext = '0;
              if (oDUTY != DUTY_MAX) dutyNext = oDUTY + PWM_BITS'(1);
              if (dutyNext == DUTY_MAX) stateNext = HOLD_HI;
            end else begin
              msCntNext = msCnt + MS_W'(1);
            end
          end
        end
        HOLD_HI: begin
          if (tick) begin
            if (msCnt == HOLD_LAST) begin
              stateNext = DOWN;
              msCntNext = '0;
            end else begin
              msCntNext = msCnt + MS_W'(1);
            end
          end
        end
        DOWN: begin
          if (tick) begin
            if (msCnt == STEP_LAST) begin
              msCntNext = '0;
              if (oDUTY != '0) dutyNext = oDUTY - PWM_BITS'(1);
              if (dutyNext == '0) stateNext = HOLD_LO;
            end else begin
              msCntNext = msCnt + MS_W'(1);
            end
          end
        end
        HOLD_LO: begin
          if (tick) begin
            if (msCnt == HOLD_LAST) begin
              stateNext = UP;
              msCntNext = '0;
              cycleNext = 1'b1;
            end else begin
              msCntNext = msCnt + MS_W'(1);
            end
          end
        end
        default: begin
          stateNext = IDLE;
          dutyNext  = '0;
          msCntNext = '0;
        end
      endcase
    end
  end

  // Duty is sampled only at the period boundary so a PWM period never glitches.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tickQ      <= 1'b0;
      pwmCnt     <= '0;
      dutyActive <= '0;
      oLED       <= 1'b0;
    end else begin
      tickQ  <= iTICK_1MS;
      pwmCnt <= pwmCnt + PWM_BITS'(1);
      if (!iEN) begin
        dutyActive <= '0;
        oLED       <= 1'b0;
      end else begin
        if (pwmCnt == DUTY_MAX) dutyActive <= oDUTY;
        oLED <= (state != IDLE) && (pwmCnt < dutyActive);
      end
    end
  end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb/tb_led_breathe_pwm.sv - randomized tick/enable stimulus with a tick-count reference model and scoreboard
module tb_led_breathe_pwm;

  localparam int PW   = 4;
  localparam int STEP = 2;
  localparam int HOLD = 3;
  localparam int MAXD = (1 << PW) - 1;
  localparam int UPT  = MAXD * STEP;
  localparam int PER  = 2 * UPT + 2 * HOLD;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iTICK_1MS = 1'b0;
  logic          iEN = 1'b0;
  logic          oLED;
  logic [PW-1:0] oDUTY;
  logic [2:0]    oSTATE;
  logic          oCYCLE;

  always #5 iCLK = ~iCLK;

  led_breathe_pwm #(.PWM_BITS(PW), .STEP_MS(STEP), .HOLD_MS(HOLD)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iTICK_1MS(iTICK_1MS), .iEN(iEN),
    .oLED(oLED), .oDUTY(oDUTY), .oSTATE(oSTATE), .oCYCLE(oCYCLE)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [PW-1:0] duty;
    logic          led;
    logic          cyc;
  } expT;

  expT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Position within one breath, measured in counted ticks since enable.
  function automatic void refAt(input int p, output logic [2:0] st, output logic [PW-1:0] d);
    if (p < UPT) begin
      st = 3'd1; d = PW'(p / STEP);
    end else if (p < UPT + HOLD) begin
      st = 3'd2; d = PW'(MAXD);
    end else if (p < 2 * UPT + HOLD) begin
      st = 3'd3; d = PW'(MAXD - (p - UPT - HOLD) / STEP);
    end else begin
      st = 3'd4; d = '0;
    end
  endfunction

  int            nTicks, phase, pwmPh, act;
  bit            prevTk, running, edgeSeen;
  logic [PW-1:0] dutyPre, refDuty;
  logic [2:0]    refSt;
  expT           mexp;

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      nTicks = 0; phase = 0; prevTk = 0; running = 0; act = 0; dutyPre = '0;
      expQ.delete();
    end else begin
      edgeSeen = iTICK_1MS && !prevTk;
      prevTk = iTICK_1MS;
      pwmPh = phase % (MAXD + 1);
      phase++;
      mexp = '0;
      if (!iEN) begin
        running = 0; nTicks = 0; act = 0; dutyPre = '0;
      end else begin
        mexp.led = (pwmPh < act);
        if (pwmPh == MAXD) act = int'(dutyPre);
        if (!running) begin
          running = 1; nTicks = 0;
        end else if (edgeSeen) begin
          nTicks++;
          mexp.cyc = (nTicks % PER == 0);
        end
        refAt(nTicks % PER, refSt, refDuty);
        mexp.st = refSt;
        mexp.duty = refDuty;
        dutyPre = refDuty;
      end
      expQ.push_back(mexp);
    end
  end

  expT pexp;
  always @(negedge iCLK) begin
    if (iRST_N && expQ.size() > 0) begin
      pexp = expQ.pop_front();
      vectors++;
      if ({oSTATE, oDUTY, oLED, oCYCLE} !== pexp) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t: state/duty/led/cycle got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                 $time, oSTATE, oDUTY, oLED, oCYCLE, pexp.st, pexp.duty, pexp.led, pexp.cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  int hiLeft = 0;
  int gapLeft = 10;

  task automatic step(input bit en);
    @(posedge iCLK);
    #1;
    iEN = en;
    if (hiLeft > 0) begin
      iTICK_1MS = 1'b1;
      hiLeft--;
    end else begin
      iTICK_1MS = 1'b0;
      if (gapLeft > 0) gapLeft--;
      else begin
        hiLeft  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 5)) : 1;
        gapLeft = $urandom_range(3, 24);
      end
    end
  endtask

  bit found;

  initial begin
    iRST_N = 1'b0;
    repeat (20) step(1'b1);
    chk("reset_led", oLED, 0);
    chk("reset_duty", oDUTY, 0);
    chk("reset_state", oSTATE, 0);
    chk("reset_cycle", oCYCLE, 0);
    iRST_N = 1'b1;
    repeat (3200) step(1'b1);

    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(1'b1);
      if (oSTATE == 3'd3 && oDUTY == PW'(9)) found = 1;
    end
    chk("find_down_duty9", found, 1);
    step(1'b0);
    step(1'b0);
    chk("disable_state", oSTATE, 0);
    chk("disable_duty", oDUTY, 0);
    chk("disable_led", oLED, 0);
    repeat (30) step(1'b0);
    step(1'b1);
    step(1'b1);
    chk("reenable_state", oSTATE, 1);
    chk("reenable_duty", oDUTY, 0);

    repeat (2000) step($urandom_range(0, 199) != 0);

    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step(1'b1);
      if (oSTATE == 3'd1 && oDUTY >= PW'(3)) found = 1;
    end
    chk("find_mid_ramp", found, 1);
    #2 iRST_N = 1'b0;
    #1;
    chk("async_rst_led", oLED, 0);
    chk("async_rst_duty", oDUTY, 0);
    chk("async_rst_state", oSTATE, 0);
    chk("async_rst_cycle", oCYCLE, 0);
    repeat (5) step(1'b1);
    iRST_N = 1'b1;
    repeat (800) step(1'b1);

    @(negedge iCLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
